// File: rtl/frame_wr_ctrl.sv
// Write-side frame buffer controller: stores a 4-pixel/word AXI4-Stream video into a ring of frame
// buffers via AXI4 INCR bursts. Define FRAME_WR_CTRL_BRESP_CHECK_EN to flag non-OKAY bresp as a frame error.
module frame_wr_ctrl #(
  parameter longint unsigned START_ADDR    = 0,
  parameter int              FRAMES_AMOUNT = 3,
  parameter int              FRAME_RES_Y   = 1080,
  parameter int              FRAME_RES_X   = 1920,
  parameter int              ADDR_WIDTH    = 32,
  parameter int              DATA_WIDTH    = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  // video stream slave
  input  logic [DATA_WIDTH-1:0]            video_tdata_i,
  input  logic                             video_tvalid_i,
  output logic                             video_tready_o,
  input  logic                             video_tlast_i,
  input  logic                             video_tuser_i,
  // AXI4 write master
  output logic [ADDR_WIDTH-1:0]            mem_awaddr_o,
  output logic [7:0]                       mem_awlen_o,
  output logic [2:0]                       mem_awsize_o,
  output logic [1:0]                       mem_awburst_o,
  output logic                             mem_awvalid_o,
  input  logic                             mem_awready_i,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          mem_wstrb_o,
  output logic                             mem_wlast_o,
  output logic                             mem_wvalid_o,
  input  logic                             mem_wready_i,
`ifdef FRAME_WR_CTRL_BRESP_CHECK_EN
  input  logic [1:0]                       mem_bresp_i,
`endif
  input  logic                             mem_bvalid_i,
  output logic                             mem_bready_o,
  output logic [ADDR_WIDTH-1:0]            mem_araddr_o,
  output logic [7:0]                       mem_arlen_o,
  output logic [2:0]                       mem_arsize_o,
  output logic [1:0]                       mem_arburst_o,
  output logic                             mem_arvalid_o,
  output logic                             mem_rready_o,
  // buffer hand-off with the read side
  input  logic [$clog2(FRAMES_AMOUNT)-1:0] rd_frame_idx_i,
  output logic [$clog2(FRAMES_AMOUNT)-1:0] wr_frame_idx_o,
  output logic                             wr_done_stb_o,
  output logic                             frame_err_stb_o
);

  localparam int IDX_W          = $clog2(FRAMES_AMOUNT);
  localparam int WORDS_PER_LINE = (FRAME_RES_X + 3) / 4;
  localparam int BYTES_PER_LINE = WORDS_PER_LINE * 8;
  localparam longint unsigned BPF_L = longint'(BYTES_PER_LINE) * longint'(FRAME_RES_Y);
  localparam logic [ADDR_WIDTH-1:0] BYTES_PER_FRAME = ADDR_WIDTH'(BPF_L);
  localparam int LW = $clog2(WORDS_PER_LINE + 1);
  localparam int YW = $clog2(FRAME_RES_Y + 1);
  localparam int CW = (LW > 10) ? LW : 10;

  typedef enum logic [2:0] {
    S_WAIT_SOF,
    S_SEL_BUF,
    S_AW,
    S_W,
    S_B
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LW-1:0]           line_left_q;   // beats of the line not yet claimed by an AW
  logic [8:0]              beats_left_q;  // beats left in the current burst
  logic [YW-1:0]           line_q;
  logic                    first_q;
  logic                    err_q;
  logic                    awvalid_q;
  logic [IDX_W-1:0]        sel_idx_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic                    done_stb_q;
  logic                    err_stb_q;

  logic [IDX_W-1:0]        sel_idx_d;
  logic [ADDR_WIDTH-1:0]   frame_base_d;
  logic [9:0]              page_beats;
  logic [9:0]              page_cap;
  logic [CW-1:0]           left_w;
  logic [8:0]              burst_len;
  logic                    w_beat;
  logic                    line_last;
  logic                    beat_err;
  logic                    bresp_err;

  function automatic logic [IDX_W-1:0] ring_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(FRAMES_AMOUNT - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    sel_idx_d = ring_inc(wr_idx_q);
    if (sel_idx_d == rd_frame_idx_i) sel_idx_d = ring_inc(sel_idx_d);
    frame_base_d = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(sel_idx_d) * BYTES_PER_FRAME;
  end

  // Burst length = min(256, beats left in line, beats left before the next 4 KB page).
  always_comb begin
    page_beats = 10'd512 - {1'b0, addr_q[11:3]};
    page_cap   = (page_beats > 10'd256) ? 10'd256 : page_beats;
    left_w     = CW'(line_left_q);
    burst_len  = (left_w < CW'(page_cap)) ? left_w[8:0] : page_cap[8:0];
  end

  assign w_beat    = (state_q == S_W) && video_tvalid_i && mem_wready_i;
  assign line_last = (beats_left_q == 9'd1) && (line_left_q == '0);
  assign beat_err  = (video_tuser_i && !first_q) || (video_tlast_i != line_last);

`ifdef FRAME_WR_CTRL_BRESP_CHECK_EN
  assign bresp_err = (mem_bresp_i != 2'b00);
`else
  assign bresp_err = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_WAIT_SOF;
      addr_q       <= '0;
      line_left_q  <= '0;
      beats_left_q <= '0;
      line_q       <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
      awvalid_q    <= 1'b0;
      sel_idx_q    <= '0;
      wr_idx_q     <= IDX_W'(FRAMES_AMOUNT - 1);
      done_stb_q   <= 1'b0;
      err_stb_q    <= 1'b0;
    end else begin
      done_stb_q <= 1'b0;
      err_stb_q  <= 1'b0;
      case (state_q)
        S_WAIT_SOF: begin
          if (video_tvalid_i && video_tuser_i) state_q <= S_SEL_BUF;
        end
        S_SEL_BUF: begin
          sel_idx_q   <= sel_idx_d;
          addr_q      <= frame_base_d;
          line_left_q <= LW'(WORDS_PER_LINE);
          line_q      <= '0;
          err_q       <= 1'b0;
          first_q     <= 1'b1;
          awvalid_q   <= 1'b1;
          state_q     <= S_AW;
        end
        S_AW: begin
          if (mem_awready_i) begin
            awvalid_q    <= 1'b0;
            beats_left_q <= burst_len;
            addr_q       <= addr_q + ADDR_WIDTH'({burst_len, 3'b000});
            line_left_q  <= line_left_q - LW'(burst_len);
            state_q      <= S_W;
          end
        end
        S_W: begin
          if (w_beat) begin
            first_q      <= 1'b0;
            beats_left_q <= beats_left_q - 9'd1;
            if (beat_err) err_q <= 1'b1;
            if (beats_left_q == 9'd1) state_q <= S_B;
          end
        end
        S_B: begin
          if (mem_bvalid_i) begin
            if (bresp_err) err_q <= 1'b1;
            if (line_left_q != '0) begin
              awvalid_q <= 1'b1;
              state_q   <= S_AW;
            end else if (line_q != YW'(FRAME_RES_Y - 1)) begin
              // Lines are contiguous, so addr_q already points at the next line.
              line_q      <= line_q + YW'(1);
              line_left_q <= LW'(WORDS_PER_LINE);
              awvalid_q   <= 1'b1;
              state_q     <= S_AW;
            end else begin
              state_q <= S_WAIT_SOF;
              if (err_q || bresp_err) begin
                err_stb_q <= 1'b1;
              end else begin
                done_stb_q <= 1'b1;
                wr_idx_q   <= sel_idx_q;
              end
            end
          end
        end
        default: state_q <= S_WAIT_SOF;
      endcase
    end
  end

  // In WAIT_SOF non-SOF words are drained; the SOF word is held until the first burst is open.
  assign video_tready_o = !rst_i && (((state_q == S_WAIT_SOF) && !video_tuser_i) ||
                                     ((state_q == S_W) && mem_wready_i));

  assign mem_awaddr_o  = addr_q;
  assign mem_awlen_o   = burst_len[7:0] - 8'd1;
  assign mem_awsize_o  = 3'd3;
  assign mem_awburst_o = 2'b01;
  assign mem_awvalid_o = awvalid_q;
  assign mem_wdata_o   = video_tdata_i;
  assign mem_wstrb_o   = '1;
  assign mem_wlast_o   = (state_q == S_W) && (beats_left_q == 9'd1);
  assign mem_wvalid_o  = (state_q == S_W) && video_tvalid_i;
  assign mem_bready_o  = 1'b1;

  assign mem_araddr_o  = '0;
  assign mem_arlen_o   = '0;
  assign mem_arsize_o  = '0;
  assign mem_arburst_o = '0;
  assign mem_arvalid_o = 1'b0;
  assign mem_rready_o  = 1'b0;

  assign wr_frame_idx_o  = wr_idx_q;
  assign wr_done_stb_o   = done_stb_q;
  assign frame_err_stb_o = err_stb_q;

endmodule
